// File: rtl/stream_downsize.sv
// stream_downsize: splits one wide beat of T_DATA_RATIO narrow lanes into a stream of
// narrow words, lane 0 first, skipping lanes whose keep bit is clear.
//
// Build option:
//   STREAM_DOWNSIZE_SPARSE_KEEP_EN  defined   -> s_keep_i may be sparse; every kept lane is sent.
//                                   undefined -> s_keep_i is taken as contiguous from lane 0;
//                                                lanes at and above the lowest clear bit are dropped.
//
// Reset rst_n is asynchronous and active-high (asserted when rst_n = 1).

module stream_downsize #(
    parameter int unsigned T_DATA_WIDTH = 1,
    parameter int unsigned T_DATA_RATIO = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
    input  logic [T_DATA_RATIO-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,

    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int unsigned IdxW = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;
    localparam logic [T_DATA_RATIO-1:0] KeepOne = T_DATA_RATIO'(1);

    typedef enum logic [0:0] {StEmpty, StSend} state_e;

    state_e                  state_q, state_d;

    logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] keep_q, keep_d;
    logic                    last_q, last_d;

    logic [T_DATA_RATIO-1:0] eff_keep;
    logic [T_DATA_RATIO-1:0] lane_oh;
    logic [T_DATA_RATIO-1:0] keep_rest;
    logic [IdxW-1:0]         lane_idx;
    logic                    in_send;
    logic                    m_xfer;
    logic                    final_xfer;
    logic                    s_accept;

    // Effective keep mask of the incoming beat.
    always_comb begin
        eff_keep = '0;
`ifdef STREAM_DOWNSIZE_SPARSE_KEEP_EN
        eff_keep = s_keep_i;
`else
        // (~k & (k + 1)) isolates the lowest clear bit; subtracting one leaves the run of
        // set bits below it. An all-ones mask wraps to zero and comes back as all-ones.
        eff_keep = ((~s_keep_i) & (s_keep_i + KeepOne)) - KeepOne;
`endif
    end

    // Lowest remaining kept lane, its index, and the mask left once it has gone.
    always_comb begin
        lane_oh   = keep_q & ((~keep_q) + KeepOne);
        keep_rest = keep_q & ~lane_oh;
        lane_idx  = '0;
        for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
            if (keep_q[i]) begin
                lane_idx = IdxW'(i);
            end
        end
    end

    // Handshake decode shared by the next-state and output logic.
    always_comb begin
        in_send    = (state_q == StSend);
        m_xfer     = in_send && m_ready_i;
        final_xfer = m_xfer && (keep_rest == '0);
        s_accept   = s_valid_i && s_ready_o;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and buffer next values; a new beat overrides the drain of the old one.
    always_comb begin
        state_d = state_q;
        keep_d  = keep_q;
        last_d  = last_q;
        if (m_xfer) begin
            keep_d = keep_rest;
        end
        if (final_xfer) begin
            state_d = StEmpty;
        end
        if (s_accept) begin
            keep_d  = eff_keep;
            last_d  = s_last_i;
            // A beat with nothing to send leaves no trace, including its last flag.
            state_d = (eff_keep != '0) ? StSend : StEmpty;
        end
    end

    // Buffered beat: data, remaining-lane mask and last flag.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                data_q[i] <= '0;
            end
            keep_q <= '0;
            last_q <= 1'b0;
        end else begin
            if (s_accept) begin
                for (int i = 0; i < T_DATA_RATIO; i++) begin
                    data_q[i] <= s_data_i[i];
                end
            end
            keep_q <= keep_d;
            last_q <= last_d;
        end
    end

    // FSM outputs; the buffer only changes on a transfer, so held words stay stable.
    always_comb begin
        m_valid_o = in_send;
        m_data_o  = in_send ? data_q[lane_idx] : '0;
        m_last_o  = in_send && last_q && (keep_rest == '0);
        // Ready while empty, or while the last lane leaves, so beats chain without a bubble.
        s_ready_o = !rst_n && ((state_q == StEmpty) || final_xfer);
    end

endmodule
